// File: rtl/adder_pkg.sv
// Shared defaults for the pipelined parallel-prefix adder stages
// (pre-processing, prefix and sum stages all import these).
package adder_pkg;
  localparam int ADDER_N          = 7;
  localparam int ADDER_PREFIX_LAT = 2;
  localparam int ADDER_CNT_W      = 16;
endpackage

// File: rtl/adder_delay_line.sv
// Generic async-reset shift register: DEPTH stages of WIDTH bits, shifting
// every cycle with no stall; o_data is the oldest stage.
module adder_delay_line #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift register; reset clears every stage so nothing in flight survives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/adder_sum_stage.sv
// Sum stage of the pipelined prefix adder: aligns half-sums/carry-in with the
// prefix result, forms carries and registers sum/cout/valid. Option: ADDER_SUM_OVF_EN.
module adder_sum_stage
  import adder_pkg::*;
#(
  parameter int N          = ADDER_N,
  parameter int PREFIX_LAT = ADDER_PREFIX_LAT,
  parameter int CNT_W      = ADDER_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [N-1:0]     p_in,
  input  logic             cin,
  input  logic [N-1:0]     g_grp,
  input  logic [N-1:0]     p_grp,
  output logic [N-1:0]     sum,
  output logic             cout,
  output logic             out_ovf,
  output logic             out_valid,
  output logic [CNT_W-1:0] res_cnt
);

  logic [N+1:0]     w_tail;
  logic             w_tail_valid;
  logic [N-1:0]     w_tail_p;
  logic             w_tail_cin;
  logic [N:0]       w_carry;
  logic [N-1:0]     w_sum_d;

  logic [N-1:0]     r_sum;
  logic             r_cout;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;

  adder_delay_line #(
    .WIDTH (N + 2),
    .DEPTH (PREFIX_LAT)
  ) u_delay (
    .clk    (clk),
    .reset  (reset),
    .i_data ({in_valid, p_in, cin}),
    .o_data (w_tail)
  );

  assign {w_tail_valid, w_tail_p, w_tail_cin} = w_tail;

  // Group terms are the cin=0 view, so cin is folded in through P here.
  assign w_carry = {g_grp | (p_grp & {N{w_tail_cin}}), w_tail_cin};
  assign w_sum_d = w_tail_p ^ w_carry[N-1:0];

  // Output register: load on a valid tail, otherwise hold data and drop valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (w_tail_valid) begin
      r_sum   <= w_sum_d;
      r_cout  <= w_carry[N];
      r_valid <= 1'b1;
      r_cnt   <= r_cnt + CNT_W'(1);
    end else begin
      r_valid <= 1'b0;
    end
  end

`ifdef ADDER_SUM_OVF_EN
  logic r_ovf;

  // Signed overflow: carry into and out of the sign bit disagree
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_tail_valid) begin
      r_ovf <= w_carry[N] ^ w_carry[N-1];
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign out_ovf = r_ovf;
`else
  assign out_ovf = 1'b0;
`endif

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign out_valid = r_valid;
  assign res_cnt   = r_cnt;

endmodule

// File: tb/tb_adder_sum_stage.sv
// Self-checking bench for adder_sum_stage (N=7, PREFIX_LAT=2): models the
// prefix stage and checks every cycle against an arithmetic reference.
module tb_adder_sum_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [6:0]  p_in;
  logic        cin;
  logic [6:0]  g_grp;
  logic [6:0]  p_grp;
  logic [6:0]  sum;
  logic        cout;
  logic        out_ovf;
  logic        out_valid;
  logic [15:0] res_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit       v;
    bit [6:0] a;
    bit [6:0] b;
    bit       c;
  } op_t;

  op_t hist[3];

  bit [6:0]  m_sum;
  bit        m_cout;
  bit        m_ovf;
  bit        m_valid;
  bit [15:0] m_cnt;

  always #5 clk = ~clk;

  adder_sum_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .p_in      (p_in),
    .cin       (cin),
    .g_grp     (g_grp),
    .p_grp     (p_grp),
    .sum       (sum),
    .cout      (cout),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .res_cnt   (res_cnt)
  );

  // Prefix-stage model: G[i:0] is the carry out of bit i when adding a[i:0]+b[i:0].
  function automatic bit [6:0] prefix_g(bit [6:0] a, bit [6:0] b);
    bit [6:0] g;
    for (int i = 0; i < 7; i++) begin
      int m;
      int s;
      m = (1 << (i + 1)) - 1;
      s = (int'(a) & m) + (int'(b) & m);
      g[i] = s[i+1];
    end
    return g;
  endfunction

  function automatic bit [6:0] prefix_p(bit [6:0] p);
    bit [6:0] r;
    for (int i = 0; i < 7; i++) begin
      int m;
      m = (1 << (i + 1)) - 1;
      r[i] = ((int'(p) & m) == m);
    end
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("sum", {25'd0, sum}, {25'd0, m_sum});
    check("cout", {31'd0, cout}, {31'd0, m_cout});
`ifdef ADDER_SUM_OVF_EN
    check("out_ovf", {31'd0, out_ovf}, {31'd0, m_ovf});
`else
    check("out_ovf", {31'd0, out_ovf}, 32'd0);
`endif
    check("res_cnt", {16'd0, res_cnt}, {16'd0, m_cnt});
  endtask

  task automatic model_update();
    bit [7:0] s;
    m_valid = hist[2].v;
    if (hist[2].v) begin
      s      = {1'b0, hist[2].a} + {1'b0, hist[2].b} + {7'd0, hist[2].c};
      m_sum  = s[6:0];
      m_cout = s[7];
      m_ovf  = (hist[2].a[6] == hist[2].b[6]) && (s[6] != hist[2].a[6]);
      m_cnt  = m_cnt + 16'd1;
    end
  endtask

  task automatic step(bit v, bit [6:0] a, bit [6:0] b, bit c);
    @(negedge clk);
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = '{v, a, b, c};
    in_valid = v;
    p_in     = a ^ b;
    cin      = c;
    g_grp    = prefix_g(hist[2].a, hist[2].b);
    p_grp    = prefix_p(hist[2].a ^ hist[2].b);
    @(posedge clk);
    #1;
    model_update();
    compare();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 7'h00, 7'h00, 1'b0);
    end
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hist[i] = '{1'b0, 7'h00, 7'h00, 1'b0};
    end
    m_sum = 7'h00; m_cout = 1'b0; m_ovf = 1'b0; m_valid = 1'b0; m_cnt = 16'd0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      compare();
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; p_in = 7'h00; cin = 1'b0;
    g_grp = 7'h00; p_grp = 7'h00;
    do_reset(2);

    // 1: 0x3F + 0x01 crosses into the sign bit
    step(1'b1, 7'h3F, 7'h01, 1'b0);
    idle(2);
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_sum", {25'd0, sum}, 32'h40);
    check("t1_cout", {31'd0, cout}, 32'd0);
`ifdef ADDER_SUM_OVF_EN
    check("t1_ovf", {31'd0, out_ovf}, 32'd1);
`endif

    // 2: max + max + cin
    step(1'b1, 7'h7F, 7'h7F, 1'b1);
    idle(2);
    check("t2_sum", {25'd0, sum}, 32'h7F);
    check("t2_cout", {31'd0, cout}, 32'd1);
    check("t2_ovf", {31'd0, out_ovf}, 32'd0);

    // 3: all-propagate with cin=1 then cin=0
    step(1'b1, 7'h7F, 7'h00, 1'b1);
    step(1'b1, 7'h7F, 7'h00, 1'b0);
    idle(1);
    check("t3a_sum", {25'd0, sum}, 32'h00);
    check("t3a_cout", {31'd0, cout}, 32'd1);
    idle(1);
    check("t3b_sum", {25'd0, sum}, 32'h7F);
    check("t3b_cout", {31'd0, cout}, 32'd0);

    // 4: valid pattern 1,1,1,0,1 with a bubble
    do_reset(1);
    step(1'b1, 7'h12, 7'h34, 1'b0);
    step(1'b1, 7'h55, 7'h2A, 1'b1);
    step(1'b1, 7'h40, 7'h40, 1'b0);
    step(1'b0, 7'h00, 7'h00, 1'b0);
    step(1'b1, 7'h01, 7'h7E, 1'b1);
    idle(1);
    check("t4_bubble_valid", {31'd0, out_valid}, 32'd0);
    check("t4_bubble_hold", {25'd0, sum}, 32'h00);
    idle(2);
    check("t4_cnt", {16'd0, res_cnt}, 32'd4);

    // 5: reset with two operands in flight
    do_reset(1);
    step(1'b1, 7'h11, 7'h22, 1'b0);
    step(1'b1, 7'h33, 7'h44, 1'b1);
    do_reset(1);
    idle(3);
    check("t5_no_valid", {31'd0, out_valid}, 32'd0);
    check("t5_cnt0", {16'd0, res_cnt}, 32'd0);
    step(1'b1, 7'h10, 7'h21, 1'b1);
    idle(2);
    check("t5_sum", {25'd0, sum}, 32'h32);
    check("t5_cnt1", {16'd0, res_cnt}, 32'd1);

    // 6: counter wrap
    do_reset(1);
    for (int i = 0; i < 65535; i++) begin
      step(1'b1, 7'($urandom), 7'($urandom), 1'($urandom));
    end
    step(1'b1, 7'h3F, 7'h01, 1'b0);
    idle(1);
    check("t6_cnt_max", {16'd0, res_cnt}, 32'hFFFF);
    idle(1);
    check("t6_cnt_wrap", {16'd0, res_cnt}, 32'd0);
    check("t6_sum", {25'd0, sum}, 32'h40);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
